// File: rtl/move_input_ctrl.sv
// Direction-button front end: sync, debounce, edge-detect, arbitrate, lock out.
// Ports: clk/reset, btn_n/s/e/w raw buttons, sw/win/die room flags -> n/s/e/w pulses, k.
module move_input_ctrl #(
  parameter int DB_LIMIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  input  logic btn_s,
  input  logic btn_e,
  input  logic btn_w,
  input  logic sw,
  input  logic win,
  input  logic die,
  output logic n,
  output logic s,
  output logic e,
  output logic w,
  output logic k
);

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DB_LIMIT - 1);

  // bit order everywhere: 0=N, 1=S, 2=E, 3=W
  logic [3:0]       w_btn;
  logic [3:0]       w_cand;
  logic [3:0]       w_grant;
  logic             w_lock;

  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [3:0]       r_stable;
  logic [3:0]       r_stable_d;
  logic [3:0]       r_rise;
  logic [3:0]       r_mv;
  logic             r_k;
  logic [CNT_W-1:0] r_cnt [4];

  assign w_btn  = {btn_w, btn_e, btn_s, btn_n};
  assign w_lock = win | die;
  assign w_cand = w_lock ? 4'b0000 : r_rise;

  // fixed priority N > S > E > W; losers are dropped
  always_comb begin
    w_grant = 4'b0000;
    if (w_cand[0])      w_grant = 4'b0001;
    else if (w_cand[1]) w_grant = 4'b0010;
    else if (w_cand[2]) w_grant = 4'b0100;
    else if (w_cand[3]) w_grant = 4'b1000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      r_rise     <= '0;
      r_mv       <= '0;
      r_k        <= 1'b0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1    <= w_btn;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      // registered rise keeps edge detect off the arbitration path
      r_rise     <= r_stable & ~r_stable_d;
      r_mv       <= w_grant;
      if (sw) r_k <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == LP_CNT_MAX) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign n = r_mv[0];
  assign s = r_mv[1];
  assign e = r_mv[2];
  assign w = r_mv[3];
  assign k = r_k;

endmodule

// File: tb/tb_move_input_ctrl.sv
// Bench for move_input_ctrl: directed scenarios plus random bouncing buttons.
// Compares every cycle against a run-length debounce reference model.
module tb_move_input_ctrl;

  localparam int DBL = 4;

  logic clk = 1'b0;
  logic reset, btn_n, btn_s, btn_e, btn_w, sw, win, die;
  logic n, s, e, w, k;

  always #5 clk = ~clk;

  move_input_ctrl #(.DB_LIMIT(DBL), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .btn_n(btn_n), .btn_s(btn_s), .btn_e(btn_e), .btn_w(btn_w),
    .sw(sw), .win(win), .die(die),
    .n(n), .s(s), .e(e), .w(w), .k(k)
  );

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [3:0] m_h1 = '0, m_h2 = '0, m_stab = '0;
  logic [3:0] m_rd1 = '0, m_rr = '0, m_out = '0;
  logic       m_k = 1'b0;
  int         m_run [4] = '{0, 0, 0, 0};

  // scenario bookkeeping
  int t = 0;
  int cnt_p [4];
  int first_p [4];

  task automatic clr();
    t = 0;
    for (int i = 0; i < 4; i++) begin
      cnt_p[i] = 0;
      first_p[i] = -1;
    end
  endtask

  task automatic model(input logic [3:0] b, input logic isw,
                       input logic ilock, input logic irst);
    logic [3:0] nr;
    logic [3:0] c;
    if (irst) begin
      m_h1 = '0; m_h2 = '0; m_stab = '0;
      m_rd1 = '0; m_rr = '0; m_out = '0; m_k = 1'b0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
    end else begin
      c = ilock ? 4'b0000 : m_rr;
      m_out = '0;
      for (int i = 3; i >= 0; i--) if (c[i]) m_out = 4'b0001 << i;
      m_rr = m_rd1;
      nr = '0;
      // stable changes after DBL consecutive samples differing from it
      for (int i = 0; i < 4; i++) begin
        if (m_h2[i] != m_stab[i]) begin
          m_run[i]++;
          if (m_run[i] == DBL) begin
            m_stab[i] = m_h2[i];
            m_run[i] = 0;
            nr[i] = m_h2[i];
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_rd1 = nr;
      m_h2 = m_h1;
      m_h1 = b;
      if (isw) m_k = 1'b1;
    end
  endtask

  task automatic step(input logic [3:0] b, input logic isw, input logic iwin,
                      input logic idie, input logic irst);
    logic [3:0] obs;
    btn_n = b[0]; btn_s = b[1]; btn_e = b[2]; btn_w = b[3];
    sw = isw; win = iwin; die = idie; reset = irst;
    @(posedge clk);
    model(b, isw, iwin | idie, irst);
    #1;
    obs = {w, e, s, n};
    checks++;
    assert (obs === m_out) else begin
      failures++;
      $error("FAIL moves t=%0d observed=%b expected=%b", t, obs, m_out);
    end
    checks++;
    assert (k === m_k) else begin
      failures++;
      $error("FAIL k t=%0d observed=%b expected=%b", t, k, m_k);
    end
    for (int i = 0; i < 4; i++) begin
      if (obs[i] === 1'b1) begin
        cnt_p[i]++;
        if (first_p[i] < 0) first_p[i] = t;
      end
    end
    t++;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic rst1(input logic [3:0] b);
    step(b, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [3:0] rb;
    btn_n = 0; btn_s = 0; btn_e = 0; btn_w = 0;
    sw = 0; win = 0; die = 0; reset = 1;
    clr();
    rst1(4'b0000);
    rst1(4'b0000);
    chk("reset_out", int'({n, s, e, w, k}), 0);

    // single east press, held
    clr();
    for (int i = 0; i < 12; i++) step(4'b0100, 0, 0, 0, 0);
    chk("t1_e_cnt", cnt_p[2], 1);
    chk("t1_e_at", first_p[2], 7);
    chk("t1_other", cnt_p[0] + cnt_p[1] + cnt_p[3], 0);
    rst1(4'b0000);

    // bouncing north then held
    clr();
    step(4'b0001, 0, 0, 0, 0);
    step(4'b0000, 0, 0, 0, 0);
    step(4'b0001, 0, 0, 0, 0);
    step(4'b0001, 0, 0, 0, 0);
    step(4'b0000, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(4'b0001, 0, 0, 0, 0);
    chk("t2_n_cnt", cnt_p[0], 1);
    chk("t2_n_at", first_p[0], 12);
    rst1(4'b0000);

    // N and W together, then W alone
    clr();
    for (int i = 0; i < 10; i++) step(4'b1001, 0, 0, 0, 0);
    chk("t3_n_cnt", cnt_p[0], 1);
    chk("t3_n_at", first_p[0], 7);
    chk("t3_w_cnt", cnt_p[3], 0);
    for (int i = 0; i < 8; i++) step(4'b0000, 0, 0, 0, 0);
    clr();
    for (int i = 0; i < 10; i++) step(4'b1000, 0, 0, 0, 0);
    chk("t3_w2_cnt", cnt_p[3], 1);
    chk("t3_w2_at", first_p[3], 7);
    rst1(4'b0000);

    // lockout, then reset with button held
    clr();
    for (int i = 0; i < 10; i++) step(4'b0010, 0, 0, 1, 0);
    chk("t4_lock_cnt", cnt_p[1], 0);
    rst1(4'b0010);
    clr();
    for (int i = 0; i < 12; i++) step(4'b0010, 0, 0, 0, 0);
    chk("t4_s_cnt", cnt_p[1], 1);
    chk("t4_s_at", first_p[1], 7);
    rst1(4'b0000);

    // sword latch
    for (int i = 0; i < 3; i++) step(4'b0000, 0, 0, 0, 0);
    chk("t5_k_before", int'(k), 0);
    step(4'b0000, 1, 0, 0, 0);
    chk("t5_k_set", int'(k), 1);
    for (int i = 0; i < 3; i++) step(4'b0000, 0, 0, 1, 0);
    chk("t5_k_die", int'(k), 1);
    rst1(4'b0000);
    chk("t5_k_rst", int'(k), 0);

    // reset mid-count
    for (int i = 0; i < 4; i++) step(4'b0100, 0, 0, 0, 0);
    rst1(4'b0100);
    chk("t6_rst_out", int'({n, s, e, w, k}), 0);
    clr();
    for (int i = 0; i < 12; i++) step(4'b0100, 0, 0, 0, 0);
    chk("t6_e_cnt", cnt_p[2], 1);
    chk("t6_e_at", first_p[2], 7);

    // random bouncing buttons, sporadic flags and resets
    rb = '0;
    for (int i = 0; i < 800; i++) begin
      for (int j = 0; j < 4; j++)
        if ($urandom_range(0, 5) == 0) rb[j] = ~rb[j];
      step(rb, ($urandom_range(0, 40) == 0),
           ($urandom_range(0, 20) == 0),
           ($urandom_range(0, 20) == 0),
           ($urandom_range(0, 120) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
